ro_monitor_ctrl: RTL
====================

Name: ro_monitor_ctrl

Overview:
- Sequencer for an on-die inverter ring-oscillator process monitor. The ring is built from inv_1 cells outside this block.
- Enables the ring, waits a settle interval, counts ring edges over a programmable window of CLK cycles, then disables the ring.
- Reports the count plus SLOW/FAST classification against programmed thresholds.
- Sits between the test/config register block and the analog-ish ring macro.

Parameters:
- CNT_W, 16, width of the edge counter and the COUNT/LO_TH/HI_TH buses
- WIN_W, 12, width of the WINDOW input
- SETTLE_CYC, 8, CLK cycles the ring runs after enable before counting starts (must be ≥1)
- SYNC_STAGES, 2, flops in the RO_CLK synchronizer (≥2)

Ports:
- CLK  input  1  system clock
- RST  input  1  reset; synchronous to CLK, active-high
- START  input  1  begin a measurement; sampled only in IDLE
- ABORT  input  1  cancel an in-progress measurement
- WINDOW  input  WIN_W  count window length in CLK cycles; latched at START
- LO_TH  input  CNT_W  below this count, SLOW is set; latched at START
- HI_TH  input  CNT_W  above this count, FAST is set; latched at START
- RO_CLK  input  1  ring output, asynchronous to CLK; frequency must be < CLK/2
- RO_EN  output  1  ring enable
- BUSY  output  1  high in SETTLE and COUNT
- DONE  output  1  one-cycle pulse when a result is posted
- COUNT  output  CNT_W  last measured edge count
- SAT  output  1  counter saturated during last measurement
- SLOW  output  1  COUNT < LO_TH
- FAST  output  1  COUNT > HI_TH
- VDD  inout  1  power, no functional role
- VSS  inout  1  ground, no functional role

Behaviour:
- Reset (RST=1 at a CLK edge):
  - state becomes IDLE.
  - RO_EN, BUSY, DONE, COUNT, SAT, SLOW and FAST all become 0.
  - synchronizer flops and the edge-detect flop clear.
  - Reset mid-measurement discards the measurement and produces no DONE.
- IDLE:
  - START=1 and ABORT=0 at edge k → latch WINDOW/LO_TH/HI_TH, RO_EN=1, BUSY=1, timer=SETTLE_CYC-1, enter SETTLE.
  - START and ABORT both high in IDLE → stay in IDLE.
- SETTLE:
  - timer decrements each cycle; no edge counting.
  - When timer==0 and latched WINDOW≠0 → enter COUNT, cnt=0, sat=0, timer=WINDOW-1.
  - When timer==0 and latched WINDOW==0 → post result with COUNT=0, SAT=0, SLOW=(0<LO_TH), FAST=0; go to IDLE.
- COUNT:
  - Each cycle a synchronized RO_CLK rising edge is detected, cnt increments.
  - cnt saturates at 2^CNT_W-1; an increment attempted at max sets sat.
  - When timer==0 → post result using cnt_next (an edge detected in the final cycle is included); go to IDLE.
- Posting a result (single edge):
  - COUNT=cnt_next, SAT=sat_next, SLOW/FAST from the latched thresholds.
  - DONE=1 for exactly one cycle.
  - RO_EN=0 and BUSY=0.
- Latency: DONE is high in the cycle after edge k+SETTLE_CYC+WINDOW, where k is the edge that sampled START.
- Hold: COUNT/SAT/SLOW/FAST hold until the next posted result or reset; a new START does not clear them.
- ABORT in SETTLE or COUNT:
  - next state IDLE; RO_EN=0, BUSY=0.
  - no DONE; result outputs keep their previous values.
  - ABORT has priority over a same-cycle final-count transition.
  - ABORT in IDLE has no effect.
- START while BUSY is ignored and is not queued.
- Synchronizer and edge detect:
  - RO_CLK passes through SYNC_STAGES flops, then a rising-edge detect: sync_q & ~sync_prev.
  - The detector runs continuously; only COUNT-state detections are counted.

Decomposition:
- Package ro_mon_pkg:
  - state enum {IDLE, SETTLE, COUNT}
  - default CNT_W/WIN_W/SETTLE_CYC constants
  - CNT_MAX function
- Sub-module ro_sync_edge (parameter SYNC_STAGES):
  - inputs CLK, RST, RO_CLK
  - output RISE, a one-cycle pulse per synchronized rising edge
- Top-level ro_monitor_ctrl holds the FSM, timer, counter, result registers and compare.

Test Plan:
1. SETTLE_CYC=8, WINDOW=100, RO_CLK driven synchronously with period 4 CLK cycles, LO_TH=20, HI_TH=30 → DONE 108 edges after START, COUNT=25, SAT=0, SLOW=0, FAST=0; RO_EN high for exactly 108 cycles.
2. CNT_W=4, WINDOW=100, RO_CLK period 4 → COUNT=15, SAT=1, FAST=1 with HI_TH=10.
3. WINDOW=0, LO_TH=1 → DONE 8 edges after START, COUNT=0, SLOW=1, and no edges counted despite a toggling RO_CLK.
4. START, then ABORT 3 cycles into COUNT → RO_EN and BUSY low next cycle, no DONE, COUNT retains the prior value (e.g. 25 from scenario 1).
5. START held high for 50 cycles during a measurement → exactly one DONE; a second START pulse 1 cycle after DONE starts a new run.
6. RST asserted mid-COUNT → next cycle all outputs 0, state IDLE, no DONE; a subsequent START behaves as in scenario 1.

Source files
------------

// File: rtl/ro_mon_pkg.sv
// Shared types and defaults for the ring-oscillator process monitor.
package ro_mon_pkg;

  typedef enum logic [1:0] {StIdle, StSettle, StCount} state_e;

  localparam int unsigned CNT_W_DEF       = 16;
  localparam int unsigned WIN_W_DEF       = 12;
  localparam int unsigned SETTLE_CYC_DEF  = 8;
  localparam int unsigned SYNC_STAGES_DEF = 2;

  // All-ones value of a width-bit counter, clamped to 32 bits.
  function automatic logic [31:0] cnt_max(input int unsigned width);
    return (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
  endfunction

endpackage

// File: rtl/ro_sync_edge.sv
// Synchronizes the free-running ring output into CLK and flags its rising edges.
module ro_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic RO_CLK,
  output logic RISE
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], RO_CLK};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign RISE = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/ro_monitor_ctrl.sv
// Ring-oscillator monitor sequencer: enable, settle, count edges over a window, classify.
module ro_monitor_ctrl
  import ro_mon_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned WIN_W       = WIN_W_DEF,
  parameter int unsigned SETTLE_CYC  = SETTLE_CYC_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             ABORT,
  input  logic [WIN_W-1:0] WINDOW,
  input  logic [CNT_W-1:0] LO_TH,
  input  logic [CNT_W-1:0] HI_TH,
  input  logic             RO_CLK,
  output logic             RO_EN,
  output logic             BUSY,
  output logic             DONE,
  output logic [CNT_W-1:0] COUNT,
  output logic             SAT,
  output logic             SLOW,
  output logic             FAST,
  inout  logic             VDD,
  inout  logic             VSS
);

  localparam int unsigned      SetW       = $clog2(SETTLE_CYC + 1);
  localparam int unsigned      TmrW       = (WIN_W > SetW) ? WIN_W : SetW;
  localparam logic [CNT_W-1:0] CntMax     = CNT_W'(cnt_max(CNT_W));
  localparam logic [TmrW-1:0]  SettleLoad = TmrW'(SETTLE_CYC - 1);

  state_e           r_state, w_state_d;
  logic [TmrW-1:0]  r_tmr, w_tmr_d;
  logic [CNT_W-1:0] r_cnt, w_cnt_d, w_cnt_nxt, w_res_cnt;
  logic             r_sat, w_sat_d, w_sat_nxt, w_res_sat;
  logic             w_post, w_load, w_rise;
  logic [WIN_W-1:0] r_win;
  logic [CNT_W-1:0] r_lo, r_hi, r_count;
  logic             r_done, r_res_sat, r_slow, r_fast;

  ro_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .CLK   (CLK),
    .RST   (RST),
    .RO_CLK(RO_CLK),
    .RISE  (w_rise)
  );

  always_comb begin
    w_cnt_nxt = r_cnt;
    w_sat_nxt = r_sat;
    if (w_rise) begin
      if (r_cnt == CntMax) w_sat_nxt = 1'b1;
      else                 w_cnt_nxt = r_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_tmr_d   = r_tmr;
    w_cnt_d   = r_cnt;
    w_sat_d   = r_sat;
    w_post    = 1'b0;
    w_load    = 1'b0;
    w_res_cnt = '0;
    w_res_sat = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (START && !ABORT) begin
          w_load    = 1'b1;
          w_tmr_d   = SettleLoad;
          w_state_d = StSettle;
        end
      end
      StSettle: begin
        if (ABORT) begin
          w_state_d = StIdle;
        end else if (r_tmr == '0) begin
          if (r_win != '0) begin
            w_state_d = StCount;
            w_cnt_d   = '0;
            w_sat_d   = 1'b0;
            w_tmr_d   = TmrW'(r_win - WIN_W'(1));
          end else begin
            // Zero-length window posts an empty result straight away.
            w_state_d = StIdle;
            w_post    = 1'b1;
          end
        end else begin
          w_tmr_d = r_tmr - TmrW'(1);
        end
      end
      StCount: begin
        if (ABORT) begin
          w_state_d = StIdle;
        end else begin
          w_cnt_d = w_cnt_nxt;
          w_sat_d = w_sat_nxt;
          if (r_tmr == '0) begin
            w_state_d = StIdle;
            w_post    = 1'b1;
            w_res_cnt = w_cnt_nxt;
            w_res_sat = w_sat_nxt;
          end else begin
            w_tmr_d = r_tmr - TmrW'(1);
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= StIdle;
      r_tmr     <= '0;
      r_cnt     <= '0;
      r_sat     <= 1'b0;
      r_win     <= '0;
      r_lo      <= '0;
      r_hi      <= '0;
      r_done    <= 1'b0;
      r_count   <= '0;
      r_res_sat <= 1'b0;
      r_slow    <= 1'b0;
      r_fast    <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_tmr   <= w_tmr_d;
      r_cnt   <= w_cnt_d;
      r_sat   <= w_sat_d;
      r_done  <= w_post;
      if (w_load) begin
        r_win <= WINDOW;
        r_lo  <= LO_TH;
        r_hi  <= HI_TH;
      end
      if (w_post) begin
        r_count   <= w_res_cnt;
        r_res_sat <= w_res_sat;
        r_slow    <= (w_res_cnt < r_lo);
        r_fast    <= (w_res_cnt > r_hi);
      end
    end
  end

  assign RO_EN = (r_state != StIdle);
  assign BUSY  = (r_state != StIdle);
  assign DONE  = r_done;
  assign COUNT = r_count;
  assign SAT   = r_res_sat;
  assign SLOW  = r_slow;
  assign FAST  = r_fast;

endmodule
